medidor_rgb: RTL and testbench
==============================

Name: medidor_rgb

Overview:
- Receive-side counterpart of the RGB motor timer.
- Watches the three one-hot motor-enable lines of one dispense frame (R phase, then G, then B) and measures how many clock cycles each phase lasts.
- Converts each phase length back to the programmed 5-bit value and presents all three with a valid/ack handshake and error flags.
- Sits between the motor driver outputs and the checking/display logic.

Parameters:
- WIDTH, 5: width of each measured value; also the saturation limit of 2^WIDTH-1.
- GAP_MAX, 15: maximum idle cycles tolerated between phases before the frame is aborted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- motor_en  in  3  phase enables. Bit0 = R, bit1 = G, bit2 = B, the same index order as the timer flags. At most one bit is high.
- ack  in  1  consumer accepts the current result.
- R_med, G_med, B_med  out  WIDTH each  measured values, held stable while valid = 1.
- valid  out  1  result available; high until acked.
- err_seq  out  1  frame had an illegal or out-of-order enable pattern, or a gap timeout.
- err_ovf  out  1  at least one phase saturated.
- overrun  out  1  sticky; a frame started while valid = 1 was dropped. Cleared by ack.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Counters are 0 and the gap timer is 0.
  - rst asserted mid-frame aborts the frame with no valid pulse.
- Encoding rule:
  - A phase held for L consecutive cycles encodes value L-1, so the sender's count 0..N lasts N+1 cycles.
  - A 1-cycle phase measures 0.
- Phase counter (cnt):
  - WIDTH+1 bits; saturates at 2^(WIDTH+1)-1.
  - The stored value is min(L-1, 2^WIDTH-1). If it clipped, err_ovf is set.
- FSM states: IDLE, MEAS_R, MEAS_G, MEAS_B, GAP, DONE.
- IDLE:
  - motor_en = 001 -> MEAS_R with cnt = 1.
  - motor_en = 000 -> stay in IDLE.
  - Any other pattern -> stay in IDLE and ignore it; this is not an error.
- MEAS_x, while its own bit is high: cnt increments.
- MEAS_x, leaving the phase:
  - On leaving, cnt-1 is stored into x_med.
  - Next bit directly (R->G, G->B) -> MEAS of the next colour with cnt = 1.
  - From MEAS_B, 000 -> DONE.
  - From MEAS_R or MEAS_G, 000 -> GAP (the gap timer counts).
  - A multi-bit pattern or a wrong next colour -> DONE with err_seq = 1. Values not yet measured are 0.
- GAP:
  - Expected next bit -> its MEAS state with cnt = 1.
  - Gap timer exceeds GAP_MAX -> DONE with err_seq = 1.
  - Any other nonzero pattern -> DONE with err_seq = 1.
- DONE:
  - valid = 1 on the cycle after entry. Results and error flags are held.
  - ack = 1 -> valid, err_seq, err_ovf and overrun are cleared next cycle; go to IDLE.
  - ack and motor_en = 001 in the same cycle -> ack is honoured and a new frame starts (MEAS_R, cnt = 1). No cycle is lost.
  - motor_en = 001 rising while valid = 1 and no ack -> overrun = 1. That frame is ignored until enables return to 000 and the FSM reaches IDLE after ack.
- Latency: valid rises 2 cycles after the last B cycle (1 cycle to detect the end of B, 1 cycle to register outputs).
- ack while valid = 0 has no effect.

Decomposition:
- Shared package rgb_pkg holds:
  - bit indices R_IDX = 0, G_IDX = 1, B_IDX = 2;
  - the one-hot constants EN_R = 001, EN_G = 010, EN_B = 100;
  - the state encoding for the FSM.
- The timer should use the same constants.
- One sub-module, contador_fase: saturating counter with load-1, increment, and saturate-detect outputs. It is instantiated once and shared across phases, since the phases are sequential.

Test Plan:
- Nominal frame: R high 4 cycles, G 8, B 1, then 000 -> R_med = 3, G_med = 7, B_med = 0, valid rises 2 cycles after B ends, no errors; ack clears valid next cycle.
- Maximum and overflow: R held 32 cycles, then G 40, B 2 -> R_med = 31 with err_ovf = 0, G_med = 31 with err_ovf = 1, B_med = 1.
- Sequence error: R 3 cycles then 100 -> valid with err_seq = 1, R_med = 2, G_med = 0, B_med = 0. Separately, 011 during G -> err_seq = 1.
- Gap handling: R 2, then 000 for 5 cycles, G 3, B 3 -> valid, R = 1, G = 2, B = 2. A gap of 16 cycles with GAP_MAX = 15 -> err_seq = 1.
- Handshake corners:
  - Second frame while valid is held without ack -> overrun = 1 and the first results are unchanged.
  - ack coincident with the first R cycle -> the new frame is measured correctly (R 5 cycles gives 4).
- Reset mid-MEAS_G -> all outputs 0 next cycle. The next clean frame measures correctly.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared constants for the RGB motor timer and its measuring counterpart:
// phase bit indices, one-hot enable codes and the measuring FSM encoding.
package rgb_pkg;

  localparam int R_IDX = 0;
  localparam int G_IDX = 1;
  localparam int B_IDX = 2;

  localparam logic [2:0] EN_OFF = 3'b000;
  localparam logic [2:0] EN_R   = 3'b001;
  localparam logic [2:0] EN_G   = 3'b010;
  localparam logic [2:0] EN_B   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEAS_R,
    ST_MEAS_G,
    ST_MEAS_B,
    ST_GAP,
    ST_DONE
  } state_t;

  // Colour that must follow the given one inside a frame (none after B).
  function automatic logic [2:0] next_colour(input logic [2:0] en);
    case (en)
      EN_R:    return EN_G;
      EN_G:    return EN_B;
      default: return EN_OFF;
    endcase
  endfunction

  function automatic state_t meas_state(input logic [2:0] en);
    case (en)
      EN_R:    return ST_MEAS_R;
      EN_G:    return ST_MEAS_G;
      default: return ST_MEAS_B;
    endcase
  endfunction

endpackage

// File: rtl/medidor_rgb_if.sv
// Motor-enable input, result/flag outputs and the valid/ack handshake of medidor_rgb.
interface medidor_rgb_if
  import rgb_pkg::*;
#(
  parameter int WIDTH = 5
);

  logic [B_IDX:0]   motor_en;
  logic             ack;
  logic [WIDTH-1:0] R_med;
  logic [WIDTH-1:0] G_med;
  logic [WIDTH-1:0] B_med;
  logic             valid;
  logic             err_seq;
  logic             err_ovf;
  logic             overrun;

  modport master (
    output motor_en, ack,
    input  R_med, G_med, B_med, valid, err_seq, err_ovf, overrun
  );

  modport slave (
    input  motor_en, ack,
    output R_med, G_med, B_med, valid, err_seq, err_ovf, overrun
  );

endinterface

// File: rtl/medidor_rgb_contador_fase.sv
// Phase-length counter shared by all three colours: load to 1, saturating
// increment, and the clipped "length minus one" value with its overflow flag.
module contador_fase #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] med_o,
  output logic             ovf_o
);

  localparam logic [WIDTH:0] CNT_MAX = '1;
  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] cnt_d;
  logic [WIDTH:0] len_m1;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_ONE;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A length of L cycles encodes L-1; the top bit of L-1 means it no longer fits.
  assign len_m1 = cnt_q - 1'b1;
  assign ovf_o  = len_m1[WIDTH];
  assign med_o  = ovf_o ? {WIDTH{1'b1}} : len_m1[WIDTH-1:0];

endmodule

// File: rtl/medidor_rgb.sv
// Measures the R, G and B phase lengths of one motor dispense frame and returns
// the encoded values with valid/ack handshake plus sequence/overflow/overrun flags.
module medidor_rgb
  import rgb_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int GAP_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  medidor_rgb_if.slave bus
);

  localparam int GW = $clog2(GAP_MAX + 1);

  state_t           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       en_prev_q;
  logic [WIDTH-1:0] r_med_q, r_med_d;
  logic [WIDTH-1:0] g_med_q, g_med_d;
  logic [WIDTH-1:0] b_med_q, b_med_d;
  logic             valid_q, valid_d;
  logic             err_seq_q, err_seq_d;
  logic             err_ovf_q, err_ovf_d;
  logic             overrun_q, overrun_d;
  logic             drop_q, drop_d;

  logic             cnt_load, cnt_inc, cnt_ovf;
  logic [WIDTH-1:0] cnt_med;
  logic [2:0]       en, own_en, nxt_en;
  logic             en_rise, start;

  assign en      = bus.motor_en;
  assign en_rise = (en == EN_R) && !en_prev_q[R_IDX];
  assign nxt_en  = next_colour(own_en);

  contador_fase #(.WIDTH(WIDTH)) u_contador (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .med_o  (cnt_med),
    .ovf_o  (cnt_ovf)
  );

  always_comb begin
    case (state_q)
      ST_MEAS_R: own_en = EN_R;
      ST_MEAS_G: own_en = EN_G;
      ST_MEAS_B: own_en = EN_B;
      default:   own_en = EN_OFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    exp_d     = exp_q;
    r_med_d   = r_med_q;
    g_med_d   = g_med_q;
    b_med_d   = b_med_q;
    valid_d   = valid_q;
    err_seq_d = err_seq_q;
    err_ovf_d = err_ovf_q;
    overrun_d = overrun_q;
    // A dropped frame stays blocked until the enables fall back to idle.
    drop_d    = drop_q && (en != EN_OFF);
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    start     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((en == EN_R) && !drop_q) begin
          start = 1'b1;
        end
      end

      ST_MEAS_R, ST_MEAS_G, ST_MEAS_B: begin
        if (en == own_en) begin
          cnt_inc = 1'b1;
        end else begin
          case (own_en)
            EN_R:    r_med_d = cnt_med;
            EN_G:    g_med_d = cnt_med;
            default: b_med_d = cnt_med;
          endcase
          err_ovf_d = err_ovf_q | cnt_ovf;
          if ((en == nxt_en) && (nxt_en != EN_OFF)) begin
            state_d  = meas_state(nxt_en);
            cnt_load = 1'b1;
          end else if (en == EN_OFF) begin
            if (state_q == ST_MEAS_B) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GAP;
              gap_d   = GW'(1);
              exp_d   = nxt_en;
            end
          end else begin
            state_d   = ST_DONE;
            err_seq_d = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (en == exp_q) begin
          state_d  = meas_state(exp_q);
          cnt_load = 1'b1;
          gap_d    = '0;
        end else if (en == EN_OFF) begin
          if (gap_q >= GW'(GAP_MAX)) begin
            state_d   = ST_DONE;
            err_seq_d = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end else begin
          state_d   = ST_DONE;
          err_seq_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (valid_q && bus.ack) begin
          valid_d   = 1'b0;
          err_seq_d = 1'b0;
          err_ovf_d = 1'b0;
          overrun_d = 1'b0;
          state_d   = ST_IDLE;
          if ((en == EN_R) && !drop_q) begin
            start = 1'b1;
          end
        end else begin
          valid_d = 1'b1;
          if (valid_q && en_rise) begin
            overrun_d = 1'b1;
            drop_d    = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_MEAS_R;
      cnt_load = 1'b1;
      r_med_d  = '0;
      g_med_d  = '0;
      b_med_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      exp_q     <= EN_OFF;
      en_prev_q <= EN_OFF;
      r_med_q   <= '0;
      g_med_q   <= '0;
      b_med_q   <= '0;
      valid_q   <= 1'b0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      exp_q     <= exp_d;
      en_prev_q <= en;
      r_med_q   <= r_med_d;
      g_med_q   <= g_med_d;
      b_med_q   <= b_med_d;
      valid_q   <= valid_d;
      err_seq_q <= err_seq_d;
      err_ovf_q <= err_ovf_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.R_med   = r_med_q;
  assign bus.G_med   = g_med_q;
  assign bus.B_med   = b_med_q;
  assign bus.valid   = valid_q;
  assign bus.err_seq = err_seq_q;
  assign bus.err_ovf = err_ovf_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_medidor_rgb.sv
// Self-checking bench for medidor_rgb: directed corner frames plus randomized
// frames, each checked against a run-length reference model of the frame rules.
module tb_medidor_rgb;
  import rgb_pkg::*;

  localparam int WIDTH   = 5;
  localparam int GAP_MAX = 15;
  localparam int MAXV    = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  medidor_rgb_if #(.WIDTH(WIDTH)) bus ();

  medidor_rgb #(.WIDTH(WIDTH), .GAP_MAX(GAP_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] stim [$];
  int         m_med [3];
  int         m_seq;
  int         m_ovf;
  int         m_det;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_run(input logic [2:0] v, input int n);
    for (int k = 0; k < n; k++) stim.push_back(v);
  endtask

  // Reference: split the stream into runs and apply the frame rules run by run.
  // m_det is the stream index of the cycle at which the frame is known to be over.
  task automatic model_frame();
    logic [2:0] cols [3];
    logic [2:0] v;
    int i, s, len, ph;
    cols   = '{EN_R, EN_G, EN_B};
    m_med  = '{0, 0, 0};
    m_seq  = 0;
    m_ovf  = 0;
    m_det  = -1;
    ph     = 0;
    i      = 0;
    while (m_det < 0) begin
      v = stim[i];
      s = i;
      while ((i < stim.size()) && (stim[i] == v)) i++;
      len = i - s;
      if (ph == 3) begin
        m_det = s;
        m_seq = (v != EN_OFF) ? 1 : 0;
      end else if (v == cols[ph]) begin
        m_med[ph] = (len - 1 > MAXV) ? MAXV : len - 1;
        if (len - 1 > MAXV) m_ovf = 1;
        ph++;
      end else if ((v == EN_OFF) && (ph > 0)) begin
        if (len > GAP_MAX) begin
          m_seq = 1;
          m_det = s + GAP_MAX;
        end
      end else begin
        m_seq = 1;
        m_det = s;
      end
    end
  endtask

  task automatic run_frame(input string name, input bit ack_first, input bit rand_ack);
    int first;
    add_run(EN_OFF, 48);
    model_frame();
    first = -1;
    for (int i = 0; (i < stim.size()) && (first < 0); i++) begin
      bus.motor_en = stim[i];
      bus.ack      = (ack_first && (i == 0)) || (rand_ack && (i > 0) && ($urandom_range(3) == 0));
      tick();
      if (ack_first && (i == 0)) begin
        check_val({name, "_ackstart_valid"}, bus.valid, 0);
        check_val({name, "_ackstart_overrun"}, bus.overrun, 0);
      end
      if (bus.valid) first = i;
    end
    bus.motor_en = EN_OFF;
    bus.ack      = 1'b0;
    check_val({name, "_latency"}, first, m_det + 1);
    check_val({name, "_R"}, bus.R_med, m_med[0]);
    check_val({name, "_G"}, bus.G_med, m_med[1]);
    check_val({name, "_B"}, bus.B_med, m_med[2]);
    check_val({name, "_err_seq"}, bus.err_seq, m_seq);
    check_val({name, "_err_ovf"}, bus.err_ovf, m_ovf);
    check_val({name, "_overrun"}, bus.overrun, 0);
    $display("frame %s: R=%0d G=%0d B=%0d err_seq=%0d err_ovf=%0d valid_at=%0d", name,
             bus.R_med, bus.G_med, bus.B_med, bus.err_seq, bus.err_ovf, first);
    stim.delete();
  endtask

  task automatic hold_and_ack(input int hold);
    for (int k = 0; k < hold; k++) tick();
    check_val("hold_valid", bus.valid, 1);
    check_val("hold_R", bus.R_med, m_med[0]);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_val("ack_valid", bus.valid, 0);
    check_val("ack_err_seq", bus.err_seq, 0);
    check_val("ack_err_ovf", bus.err_ovf, 0);
    check_val("ack_overrun", bus.overrun, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pending;
    int idx;
    bus.motor_en = EN_OFF;
    bus.ack      = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", bus.valid, 0);
    check_val("rst_R", bus.R_med, 0);
    check_val("rst_err_seq", bus.err_seq, 0);
    check_val("rst_err_ovf", bus.err_ovf, 0);
    check_val("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    tick();

    // Nominal frame
    add_run(EN_R, 4); add_run(EN_G, 8); add_run(EN_B, 1);
    run_frame("nominal", 0, 0);
    hold_and_ack(2);

    // Maximum and overflow
    add_run(EN_R, 32); add_run(EN_G, 40); add_run(EN_B, 2);
    run_frame("overflow", 0, 0);
    hold_and_ack(0);

    // Wrong next colour
    add_run(EN_R, 3); add_run(EN_B, 2);
    run_frame("seq_rb", 0, 0);
    hold_and_ack(1);

    // Multi-bit pattern during G
    add_run(EN_R, 2); add_run(EN_G, 3); add_run(3'b011, 2);
    run_frame("seq_multi", 0, 0);
    hold_and_ack(0);

    // Gap tolerated, gap timeout, and gap at the limit
    add_run(EN_R, 2); add_run(EN_OFF, 5); add_run(EN_G, 3); add_run(EN_B, 3);
    run_frame("gap5", 0, 0);
    hold_and_ack(0);
    add_run(EN_R, 2); add_run(EN_OFF, 16); add_run(EN_G, 3);
    run_frame("gap16", 0, 0);
    hold_and_ack(0);
    add_run(EN_R, 2); add_run(EN_OFF, 15); add_run(EN_G, 3); add_run(EN_B, 1);
    run_frame("gap15", 0, 0);

    // ack coincident with the first R cycle of the next frame
    add_run(EN_R, 5); add_run(EN_G, 2); add_run(EN_B, 2);
    run_frame("ack_start", 1, 0);
    hold_and_ack(0);

    // Second frame while valid is held
    add_run(EN_R, 3); add_run(EN_G, 3); add_run(EN_B, 3);
    run_frame("ovr_first", 0, 0);
    bus.motor_en = EN_R;
    repeat (3) tick();
    bus.motor_en = EN_OFF;
    repeat (3) tick();
    check_val("ovr_flag", bus.overrun, 1);
    check_val("ovr_valid", bus.valid, 1);
    check_val("ovr_R", bus.R_med, m_med[0]);
    check_val("ovr_G", bus.G_med, m_med[1]);
    check_val("ovr_B", bus.B_med, m_med[2]);
    hold_and_ack(0);
    add_run(EN_R, 4); add_run(EN_G, 2); add_run(EN_B, 6);
    run_frame("after_ovr", 0, 0);
    hold_and_ack(0);

    // Reset in the middle of G
    bus.motor_en = EN_R;
    repeat (3) tick();
    bus.motor_en = EN_G;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_val("midrst_valid", bus.valid, 0);
    check_val("midrst_R", bus.R_med, 0);
    check_val("midrst_G", bus.G_med, 0);
    check_val("midrst_err_ovf", bus.err_ovf, 0);
    check_val("midrst_err_seq", bus.err_seq, 0);
    rst = 1'b0;
    bus.motor_en = EN_OFF;
    tick();
    add_run(EN_R, 7); add_run(EN_G, 1); add_run(EN_B, 9);
    run_frame("after_rst", 0, 0);
    hold_and_ack(0);

    // Randomized frames with optional gaps, injected faults and mixed ack timing
    pending = 0;
    for (int f = 0; f < 30; f++) begin
      add_run(EN_R, $urandom_range(40, 1));
      if ($urandom_range(1) == 1) add_run(EN_OFF, $urandom_range(16, 1));
      add_run(EN_G, $urandom_range(40, 1));
      if ($urandom_range(1) == 1) add_run(EN_OFF, $urandom_range(16, 1));
      add_run(EN_B, $urandom_range(40, 1));
      if ($urandom_range(4) == 0) begin
        idx = $urandom_range(stim.size() - 1, 1);
        stim[idx] = 3'($urandom_range(7, 2));
      end
      run_frame($sformatf("rnd%0d", f), pending, 1);
      if ($urandom_range(1) == 1) begin
        hold_and_ack($urandom_range(3));
        pending = 0;
      end else begin
        pending = 1;
      end
    end
    if (pending) hold_and_ack(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
